match_sequencer: RTL and testbench

Sequencer that owns the match SRAM read port and runs one search per `Go_flag` request. It captures an 8-bit key from `DataIn` and sweeps the SRAM from address 0 upward, issuing one read per cycle. Each returned 32-bit word is compared byte-lane-wise against the key, and the scan stops at the first hit. It sits between the top-level input pins (`DataIn`, `Go_flag`) and the match SRAM, and drives the top-level `Found` result.

---
 rtl/match_pkg.sv | 27 ++
 rtl/match_lane_cmp.sv | 30 +++
 rtl/match_sequencer.sv | 121 ++++++++++++
 tb/tb_match_sequencer.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/match_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : match_pkg
//  Description : Shared defaults, state encoding and lane helper for the
//                match sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
package match_pkg;

    localparam int DEFAULT_DEPTH  = 32;
    localparam int DEFAULT_ADDR_W = 5;
    localparam int DEFAULT_DATA_W = 32;
    localparam int DEFAULT_KEY_W  = 8;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    function automatic int lane_count(input int data_w, input int key_w);
        return data_w / key_w;
    endfunction

    localparam int DEFAULT_LANES = lane_count(DEFAULT_DATA_W, DEFAULT_KEY_W);

endpackage : match_pkg
`default_nettype wire

// File: rtl/match_lane_cmp.sv
`default_nettype none
// ============================================================================
//  Module      : match_lane_cmp
//  Description : Combinational byte-lane comparator; hits when any key-sized
//                lane of the word equals the key.
//  Revision    : 1.0 - initial release
// ============================================================================
module match_lane_cmp
    import match_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int KEY_W  = DEFAULT_KEY_W
) (
    input  logic [KEY_W-1:0]  i_key,
    input  logic [DATA_W-1:0] i_word,
    output logic              o_hit
);

    localparam int LANES = lane_count(DATA_W, KEY_W);

    logic [LANES-1:0] w_lane_hit;

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        assign w_lane_hit[k] = (i_word[k*KEY_W +: KEY_W] == i_key);
    end

    assign o_hit = |w_lane_hit;

endmodule : match_lane_cmp
`default_nettype wire

// File: rtl/match_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : match_sequencer
//  Description : Owns the match SRAM read port; sweeps addresses from 0 and
//                reports the first word containing the captured key.
//  Revision    : 1.0 - initial release
// ============================================================================
module match_sequencer
    import match_pkg::*;
#(
    parameter int DEPTH  = DEFAULT_DEPTH,
    parameter int ADDR_W = DEFAULT_ADDR_W,
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int KEY_W  = DEFAULT_KEY_W
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              Go_flag,
    input  logic [KEY_W-1:0]  DataIn,
    output logic              sram_rd_en,
    output logic [ADDR_W-1:0] sram_addr,
    input  logic [DATA_W-1:0] sram_rdata,
    output logic [DATA_W-1:0] Found,
    output logic              found_valid,
    output logic [ADDR_W-1:0] match_addr,
    output logic              busy,
    output logic              done
);

    localparam logic [ADDR_W-1:0] C_LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_t              r_state;
    logic [KEY_W-1:0]    r_key;
    logic [ADDR_W-1:0]   r_addr;
    logic                r_rd_en;
    logic                r_pend;
    logic [ADDR_W-1:0]   r_pend_addr;
    logic [DATA_W-1:0]   r_found;
    logic                r_found_valid;
    logic [ADDR_W-1:0]   r_match_addr;
    logic                r_busy;
    logic                r_done;
    logic                w_hit;

    match_lane_cmp #(
        .DATA_W (DATA_W),
        .KEY_W  (KEY_W)
    ) u_cmp (
        .i_key  (r_key),
        .i_word (sram_rdata),
        .o_hit  (w_hit)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= IDLE;
            r_key         <= '0;
            r_addr        <= '0;
            r_rd_en       <= 1'b0;
            r_pend        <= 1'b0;
            r_pend_addr   <= '0;
            r_found       <= '0;
            r_found_valid <= 1'b0;
            r_match_addr  <= '0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (Go_flag) begin
                        r_state <= SCAN;
                        r_key   <= DataIn;
                        r_addr  <= '0;
                        r_rd_en <= 1'b1;
                        r_pend  <= 1'b0;
                        r_busy  <= 1'b1;
                    end
                end
                SCAN: begin
                    // r_pend marks that sram_rdata now holds the word at r_pend_addr
                    r_pend      <= r_rd_en;
                    r_pend_addr <= r_addr;
                    if (r_pend && (w_hit || (r_pend_addr == C_LAST_ADDR))) begin
                        // The read issued this edge is dropped along with the pending flag
                        r_state       <= IDLE;
                        r_rd_en       <= 1'b0;
                        r_pend        <= 1'b0;
                        r_busy        <= 1'b0;
                        r_done        <= 1'b1;
                        r_found_valid <= w_hit;
                        r_found       <= w_hit ? sram_rdata : '0;
                        r_match_addr  <= w_hit ? r_pend_addr : '0;
                    end else if (r_rd_en) begin
                        if (r_addr == C_LAST_ADDR) begin
                            r_rd_en <= 1'b0;
                        end else begin
                            r_addr <= r_addr + 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_rd_en <= 1'b0;
                    r_pend  <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign sram_rd_en  = r_rd_en;
    assign sram_addr   = r_addr;
    assign Found       = r_found;
    assign found_valid = r_found_valid;
    assign match_addr  = r_match_addr;
    assign busy        = r_busy;
    assign done        = r_done;

endmodule : match_sequencer
`default_nettype wire

// File: tb/tb_match_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_match_sequencer
//  Description : Directed vector bench for match_sequencer with an SRAM model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_match_sequencer;

    localparam int DEPTH  = 32;
    localparam int ADDR_W = 5;
    localparam int DATA_W = 32;
    localparam int KEY_W  = 8;

    logic              clock = 1'b0;
    logic              reset_n = 1'b0;
    logic              Go_flag = 1'b0;
    logic [KEY_W-1:0]  DataIn = '0;
    logic              sram_rd_en;
    logic [ADDR_W-1:0] sram_addr;
    logic [DATA_W-1:0] sram_rdata = '0;
    logic [DATA_W-1:0] Found;
    logic              found_valid;
    logic [ADDR_W-1:0] match_addr;
    logic              busy;
    logic              done;

    logic [DATA_W-1:0] mem [DEPTH];
    int                rd_cnt [DEPTH];
    int                max_rd;
    int                checks = 0;
    int                errors = 0;

    match_sequencer #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .KEY_W  (KEY_W)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .Go_flag     (Go_flag),
        .DataIn      (DataIn),
        .sram_rd_en  (sram_rd_en),
        .sram_addr   (sram_addr),
        .sram_rdata  (sram_rdata),
        .Found       (Found),
        .found_valid (found_valid),
        .match_addr  (match_addr),
        .busy        (busy),
        .done        (done)
    );

    always #5 clock = ~clock;

    // Synchronous-read SRAM: data valid one cycle after the strobe
    always @(posedge clock) begin
        if (sram_rd_en) begin
            sram_rdata <= mem[sram_addr];
            rd_cnt[sram_addr] = rd_cnt[sram_addr] + 1;
            if (int'(sram_addr) > max_rd) max_rd = int'(sram_addr);
        end
    end

    typedef struct {
        logic [7:0]  key;
        int          pa1;
        logic [31:0] pw1;
        int          pa2;
        logic [31:0] pw2;
        logic [31:0] exp_found;
        logic        exp_valid;
        logic [4:0]  exp_addr;
        int          exp_lat;
        int          exp_max;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fill_mem();
        logic [7:0] b;
        for (int i = 0; i < DEPTH; i++) begin
            b = 8'(16 + i);
            mem[i] = {4{b}};
        end
    endtask

    task automatic clear_reads();
        for (int i = 0; i < DEPTH; i++) rd_cnt[i] = 0;
        max_rd = -1;
    endtask

    task automatic go(input logic [7:0] key);
        @(posedge clock); #1;
        Go_flag = 1'b1;
        DataIn  = key;
        clear_reads();
        @(posedge clock); #1;
        Go_flag = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (!done && lat < 100) begin
            @(posedge clock); #1;
            lat++;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got no done after %0d cycles", lat);
        end
    endtask

    vec_t vecs [5];
    int   lat;
    int   ndone;
    int   done_lat;
    logic reads_ok;
    logic [31:0] held;

    initial begin
        vecs[0] = '{8'hAB,  5, 32'h12AB3456, -1, 32'h0,        32'h12AB3456, 1'b1, 5'd5,  7,  6};
        vecs[1] = '{8'hEE, -1, 32'h0,        -1, 32'h0,        32'h0,        1'b0, 5'd0,  33, 31};
        vecs[2] = '{8'h77,  3, 32'h33333377, 20, 32'h77000000, 32'h33333377, 1'b1, 5'd3,  5,  4};
        vecs[3] = '{8'h00, 31, 32'hFF00FFFF, -1, 32'h0,        32'hFF00FFFF, 1'b1, 5'd31, 33, 31};
        vecs[4] = '{8'h5A,  0, 32'h5A000000, -1, 32'h0,        32'h5A000000, 1'b1, 5'd0,  2,  1};

        fill_mem();
        clear_reads();
        repeat (2) @(posedge clock);
        #1;
        check("reset_outputs", {18'h0, Found, found_valid, match_addr, sram_addr, sram_rd_en, busy, done}, 64'h0);
        reset_n = 1'b1;

        for (int v = 0; v < 5; v++) begin
            fill_mem();
            if (vecs[v].pa1 >= 0) mem[vecs[v].pa1] = vecs[v].pw1;
            if (vecs[v].pa2 >= 0) mem[vecs[v].pa2] = vecs[v].pw2;
            go(vecs[v].key);
            check("busy_during", 64'(busy), 64'h1);
            wait_done(lat);
            check("latency",     64'(lat),         64'(vecs[v].exp_lat));
            check("found",       64'(Found),       64'(vecs[v].exp_found));
            check("found_valid", 64'(found_valid), 64'(vecs[v].exp_valid));
            check("match_addr",  64'(match_addr),  64'(vecs[v].exp_addr));
            check("max_read",    64'(max_rd),      64'(vecs[v].exp_max));
            reads_ok = 1'b1;
            for (int i = 0; i < DEPTH; i++)
                if (rd_cnt[i] != ((i <= vecs[v].exp_max) ? 1 : 0)) reads_ok = 1'b0;
            check("reads_once", 64'(reads_ok), 64'h1);
        end

        held = Found;
        repeat (3) @(posedge clock);
        #1;
        check("result_hold", {31'h0, busy, Found}, {31'h0, 1'b0, held});

        // Asynchronous abort in the middle of a scan
        fill_mem();
        go(8'hEE);
        lat = 0;
        while (sram_addr != 5'd10 && lat < 50) begin
            @(posedge clock); #1;
            lat++;
        end
        check("reached_addr10", 64'(sram_addr), 64'd10);
        reset_n = 1'b0;
        #1;
        check("abort_outputs", {18'h0, Found, found_valid, match_addr, sram_addr, sram_rd_en, busy, done}, 64'h0);
        ndone = 0;
        repeat (2) begin
            @(posedge clock); #1;
            if (done) ndone++;
        end
        reset_n = 1'b1;
        check("abort_no_done", 64'(ndone), 64'h0);
        mem[5] = 32'h12AB3456;
        go(8'hAB);
        wait_done(lat);
        check("post_reset_lat",  64'(lat),        64'd7);
        check("post_reset_addr", 64'(match_addr), 64'd5);
        check("post_reset_found", 64'(Found),     64'h12AB3456);

        // Go pulses during a search must be ignored, not queued
        fill_mem();
        go(8'hEE);
        ndone = 0;
        done_lat = 0;
        for (int c = 1; c <= 45; c++) begin
            @(posedge clock); #1;
            if (c == 4 || c == 9) begin
                Go_flag = 1'b1;
                DataIn  = 8'h10;
            end else begin
                Go_flag = 1'b0;
            end
            if (done) begin
                ndone++;
                done_lat = c;
            end
        end
        check("ignored_go_ndone", 64'(ndone),       64'd1);
        check("ignored_go_lat",   64'(done_lat),    64'd33);
        check("ignored_go_valid", 64'(found_valid), 64'h0);
        check("ignored_go_idle",  64'(busy),        64'h0);

        // Back-to-back: Go raised in the done cycle
        fill_mem();
        mem[7] = 32'h00AB0000;
        mem[0] = 32'hAAAA01AA;
        go(8'hAB);
        wait_done(lat);
        check("b2b_first_lat",  64'(lat),        64'd9);
        check("b2b_first_addr", 64'(match_addr), 64'd7);
        Go_flag = 1'b1;
        DataIn  = 8'h01;
        clear_reads();
        @(posedge clock); #1;
        Go_flag = 1'b0;
        wait_done(lat);
        check("b2b_second_lat",   64'(lat),         64'd2);
        check("b2b_second_addr",  64'(match_addr),  64'd0);
        check("b2b_second_found", 64'(Found),       64'hAAAA01AA);
        check("b2b_second_valid", 64'(found_valid), 64'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_match_sequencer
`default_nettype wire
